// File: rtl/fpu_sched_pkg.sv
// Shared types and constants for the FPU request scheduler.
// State encoding, response codes and the exception-flag width.
package fpu_sched_pkg;

    localparam int FLAG_WIDTH = 5;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        ISSUE = ST_ISSUE,
        WAIT  = ST_WAIT,
        RESP  = ST_RESP
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/fpu_req_sched_rr_arb2.sv
// Two-input round-robin arbiter: combinational grant, registered pointer.
// The pointer only breaks ties; a lone requester always wins.
module rr_arb2 (
    input  logic       clk,
    input  logic       srst,
    input  logic [1:0] req,
    input  logic       ptr_upd,
    input  logic       ptr_nxt,
    output logic       gnt_id,
    output logic       gnt_valid
);

    logic ptr;

    always_ff @(posedge clk) begin
        if (srst) begin
            ptr <= 1'b0;
        end else if (ptr_upd) begin
            ptr <= ptr_nxt;
        end
    end

    always_comb begin
        gnt_valid = |req;
        case (req)
            2'b01:   gnt_id = 1'b0;
            2'b10:   gnt_id = 1'b1;
            default: gnt_id = ptr;
        endcase
    end

endmodule

// File: rtl/fpu_req_sched.sv
// Shares one FPU core between two requesters, one operation in flight,
// with a WAIT watchdog that flushes the FPU and returns SLVERR on timeout.
//
// state | meaning
// IDLE  | arbitrate, accept one request, latch operands
// ISSUE | one-cycle fpu_start_o, clear watchdog
// WAIT  | wait for fpu_res_ready_i or watchdog expiry
// RESP  | present response to the granted requester until accepted
module fpu_req_sched
    import fpu_sched_pkg::*;
#(
    parameter int OPERAND_WIDTH  = 32,
    parameter int OP_WIDTH       = 8,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int TO_WIDTH       = $clog2(TIMEOUT_CYCLES)
) (
    input  logic                     aclk,
    input  logic                     srst,
    input  logic                     req0_valid_i,
    input  logic                     req1_valid_i,
    output logic                     req0_ready_o,
    output logic                     req1_ready_o,
    input  logic [OPERAND_WIDTH-1:0] req0_opa_i,
    input  logic [OPERAND_WIDTH-1:0] req1_opa_i,
    input  logic [OPERAND_WIDTH-1:0] req0_opb_i,
    input  logic [OPERAND_WIDTH-1:0] req1_opb_i,
    input  logic [OP_WIDTH-1:0]      req0_op_i,
    input  logic [OP_WIDTH-1:0]      req1_op_i,
    output logic                     rsp0_valid_o,
    output logic                     rsp1_valid_o,
    input  logic                     rsp0_ready_i,
    input  logic                     rsp1_ready_i,
    output logic [OPERAND_WIDTH-1:0] rsp_result_o,
    output logic [FLAG_WIDTH-1:0]    rsp_flag_o,
    output logic [1:0]               rsp_resp_o,
    output logic                     fpu_start_o,
    output logic [OPERAND_WIDTH-1:0] fpu_opa_o,
    output logic [OPERAND_WIDTH-1:0] fpu_opb_o,
    output logic [OP_WIDTH-1:0]      fpu_op_o,
    input  logic [OPERAND_WIDTH-1:0] fpu_result_i,
    input  logic                     fpu_res_ready_i,
    input  logic [FLAG_WIDTH-1:0]    fpu_flag_i,
    output logic                     fpu_flush_o,
    output logic                     busy_o,
    output logic                     grant_id_o,
    output logic [7:0]               err_cnt_o
);

    state_e                   state;
    state_e                   state_nxt;
    logic [TO_WIDTH-1:0]      to_cnt;
    logic                     arb_id;
    logic                     arb_valid;
    logic                     rsp_hs;
    logic                     timeout_hit;
    logic [OPERAND_WIDTH-1:0] sel_opa;
    logic [OPERAND_WIDTH-1:0] sel_opb;
    logic [OP_WIDTH-1:0]      sel_op;

    rr_arb2 u_arb (
        .clk       (aclk),
        .srst      (srst),
        .req       ({req1_valid_i, req0_valid_i}),
        .ptr_upd   (rsp_hs),
        .ptr_nxt   (~grant_id_o),
        .gnt_id    (arb_id),
        .gnt_valid (arb_valid)
    );

    always_comb begin
        req0_ready_o = (state == IDLE) && req0_valid_i && !arb_id;
        req1_ready_o = (state == IDLE) && req1_valid_i &&  arb_id;
        rsp0_valid_o = (state == RESP) && !grant_id_o;
        rsp1_valid_o = (state == RESP) &&  grant_id_o;
        rsp_hs       = (state == RESP) && (grant_id_o ? rsp1_ready_i : rsp0_ready_i);
        // A result arriving on the last watchdog cycle wins over the abort.
        timeout_hit  = (state == WAIT) && !fpu_res_ready_i &&
                       (to_cnt == TO_WIDTH'(TIMEOUT_CYCLES - 1));
        fpu_start_o  = (state == ISSUE);
        fpu_flush_o  = timeout_hit;
        busy_o       = (state != IDLE);
        sel_opa      = arb_id ? req1_opa_i : req0_opa_i;
        sel_opb      = arb_id ? req1_opb_i : req0_opb_i;
        sel_op       = arb_id ? req1_op_i  : req0_op_i;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (arb_valid) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (fpu_res_ready_i || timeout_hit) state_nxt = RESP;
            RESP:    if (rsp_hs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (srst) begin
            state        <= IDLE;
            to_cnt       <= '0;
            grant_id_o   <= 1'b0;
            fpu_opa_o    <= '0;
            fpu_opb_o    <= '0;
            fpu_op_o     <= '0;
            rsp_result_o <= '0;
            rsp_flag_o   <= '0;
            rsp_resp_o   <= RESP_OKAY;
            err_cnt_o    <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (arb_valid) begin
                        grant_id_o <= arb_id;
                        fpu_opa_o  <= sel_opa;
                        fpu_opb_o  <= sel_opb;
                        fpu_op_o   <= sel_op;
                    end
                end
                ISSUE: begin
                    to_cnt <= '0;
                end
                WAIT: begin
                    to_cnt <= to_cnt + 1'b1;
                    if (fpu_res_ready_i) begin
                        rsp_result_o <= fpu_result_i;
                        rsp_flag_o   <= fpu_flag_i;
                        rsp_resp_o   <= RESP_OKAY;
                    end else if (timeout_hit) begin
                        rsp_result_o <= '0;
                        rsp_flag_o   <= '0;
                        rsp_resp_o   <= RESP_SLVERR;
                        err_cnt_o    <= sat_inc8(err_cnt_o);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_req_sched.sv
// Self-checking bench for fpu_req_sched: vector table, directed corner
// sequences and randomized ops against a transaction-level reference model.
module tb_fpu_req_sched;
    import fpu_sched_pkg::*;

    logic        aclk = 1'b0;
    logic        srst;
    logic        req0_valid_i, req1_valid_i, req0_ready_o, req1_ready_o;
    logic [31:0] req0_opa_i, req1_opa_i, req0_opb_i, req1_opb_i;
    logic [7:0]  req0_op_i, req1_op_i;
    logic        rsp0_valid_o, rsp1_valid_o, rsp0_ready_i, rsp1_ready_i;
    logic [31:0] rsp_result_o;
    logic [4:0]  rsp_flag_o;
    logic [1:0]  rsp_resp_o;
    logic        fpu_start_o, fpu_flush_o, busy_o, grant_id_o;
    logic [31:0] fpu_opa_o, fpu_opb_o, fpu_result_i;
    logic [7:0]  fpu_op_o, err_cnt_o;
    logic        fpu_res_ready_i;
    logic [4:0]  fpu_flag_i;

    always #5 aclk = ~aclk;

    fpu_req_sched dut (
        .aclk(aclk), .srst(srst),
        .req0_valid_i(req0_valid_i), .req1_valid_i(req1_valid_i),
        .req0_ready_o(req0_ready_o), .req1_ready_o(req1_ready_o),
        .req0_opa_i(req0_opa_i), .req1_opa_i(req1_opa_i),
        .req0_opb_i(req0_opb_i), .req1_opb_i(req1_opb_i),
        .req0_op_i(req0_op_i), .req1_op_i(req1_op_i),
        .rsp0_valid_o(rsp0_valid_o), .rsp1_valid_o(rsp1_valid_o),
        .rsp0_ready_i(rsp0_ready_i), .rsp1_ready_i(rsp1_ready_i),
        .rsp_result_o(rsp_result_o), .rsp_flag_o(rsp_flag_o), .rsp_resp_o(rsp_resp_o),
        .fpu_start_o(fpu_start_o), .fpu_opa_o(fpu_opa_o), .fpu_opb_o(fpu_opb_o),
        .fpu_op_o(fpu_op_o), .fpu_result_i(fpu_result_i),
        .fpu_res_ready_i(fpu_res_ready_i), .fpu_flag_i(fpu_flag_i),
        .fpu_flush_o(fpu_flush_o), .busy_o(busy_o), .grant_id_o(grant_id_o),
        .err_cnt_o(err_cnt_o)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: round-robin pointer and saturating timeout count.
    int m_ptr = 0;
    int m_err = 0;

    typedef struct {
        bit          v0, v1;
        logic [31:0] a0, b0, a1, b1;
        logic [7:0]  o0, o1;
        int          dly;      // WAIT cycle of res_ready; 0 = never
        logic [31:0] fres;
        logic [4:0]  fflg;
        int          stall;
        int          exp_gnt;
        logic [1:0]  exp_resp;
        logic [31:0] exp_res;
        logic [4:0]  exp_flg;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int m_grant(bit v0, bit v1);
        if (v0 && !v1) return 0;
        if (v1 && !v0) return 1;
        return m_ptr;
    endfunction

    function automatic vec_t mk(bit v0, bit v1, logic [31:0] a, logic [31:0] b, logic [7:0] o,
                                int dly, logic [31:0] fres, logic [4:0] flg, int stall,
                                int eg, logic [1:0] er);
        vec_t v;
        v.v0 = v0; v.v1 = v1;
        v.a0 = a;  v.b0 = b;  v.o0 = o;
        v.a1 = ~a; v.b1 = b ^ 32'h5555_AAAA; v.o1 = o + 8'h80;
        v.dly = dly; v.fres = fres; v.fflg = flg; v.stall = stall;
        v.exp_gnt = eg; v.exp_resp = er;
        v.exp_res = (er == RESP_OKAY) ? fres : 32'h0;
        v.exp_flg = (er == RESP_OKAY) ? flg : 5'h0;
        return v;
    endfunction

    task automatic run_op(input vec_t v);
        int          g, waited, last;
        bit          got;
        logic [31:0] ea, eb;
        logic [7:0]  eo;
        g = v.exp_gnt;
        @(negedge aclk);
        rsp0_ready_i = 1'b0; rsp1_ready_i = 1'b0; fpu_res_ready_i = 1'b0;
        req0_valid_i = v.v0; req0_opa_i = v.a0; req0_opb_i = v.b0; req0_op_i = v.o0;
        req1_valid_i = v.v1; req1_opa_i = v.a1; req1_opb_i = v.b1; req1_op_i = v.o1;
        #1;
        chk("idle_busy", 96'(busy_o), 96'(0));
        chk("err_cnt", 96'(err_cnt_o), 96'(m_err));
        waited = 0; got = 0;
        for (int i = 0; i < 20; i++) begin
            if (req0_ready_o || req1_ready_o) begin got = 1; break; end
            @(negedge aclk); #1; waited++;
        end
        chk("req_accept", 96'(got), 96'(1));
        if (!got) begin
            req0_valid_i = 1'b0; req1_valid_i = 1'b0;
            return;
        end
        chk("ready_wait", 96'(waited), 96'(0));
        chk("grant_ready", 96'({req1_ready_o, req0_ready_o}), 96'(g ? 2'b10 : 2'b01));
        ea = g ? v.a1 : v.a0; eb = g ? v.b1 : v.b0; eo = g ? v.o1 : v.o0;

        @(negedge aclk);
        if (g == 0) req0_valid_i = 1'b0; else req1_valid_i = 1'b0;
        #1;
        chk("start_pulse", 96'(fpu_start_o), 96'(1));
        chk("grant_id", 96'(grant_id_o), 96'(g));
        chk("fpu_operands", {fpu_opa_o, fpu_opb_o, fpu_op_o, 24'h0}, {ea, eb, eo, 24'h0});
        chk("other_blocked", 96'(g ? req0_ready_o : req1_ready_o), 96'(0));

        last = (v.dly >= 1 && v.dly <= 64) ? v.dly : 64;
        for (int k = 1; k <= last; k++) begin
            @(negedge aclk);
            fpu_res_ready_i = (k == v.dly);
            fpu_result_i = v.fres; fpu_flag_i = v.fflg;
            #1;
            chk("start_once", 96'(fpu_start_o), 96'(0));
            chk("flush", 96'(fpu_flush_o), 96'((k == 64) && (v.dly != 64)));
        end

        for (int s = 0; s <= v.stall; s++) begin
            @(negedge aclk);
            // A late result after the watchdog fired must not disturb the response.
            fpu_res_ready_i = (s == 0) && (v.dly > 64);
            fpu_result_i = 32'hDEAD_BEEF; fpu_flag_i = 5'h1F;
            if (g == 0) begin rsp0_ready_i = (s == v.stall); rsp1_ready_i = 1'b1; end
            else        begin rsp1_ready_i = (s == v.stall); rsp0_ready_i = 1'b1; end
            #1;
            chk("rsp_valid", 96'({rsp1_valid_o, rsp0_valid_o}), 96'(g ? 2'b10 : 2'b01));
            chk("rsp_fields", 96'({rsp_result_o, rsp_flag_o, rsp_resp_o}),
                96'({v.exp_res, v.exp_flg, v.exp_resp}));
            chk("ops_stable", {fpu_opa_o, fpu_opb_o, fpu_op_o, 24'h0}, {ea, eb, eo, 24'h0});
            chk("other_blocked", 96'(g ? req0_ready_o : req1_ready_o), 96'(0));
        end
        m_ptr = (g == 0) ? 1 : 0;
        if (v.exp_resp == RESP_SLVERR && m_err < 255) m_err++;
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_a"}, 96'({req0_ready_o, req1_ready_o, rsp0_valid_o, rsp1_valid_o,
                              rsp_result_o, rsp_flag_o, rsp_resp_o, fpu_start_o,
                              fpu_flush_o, busy_o, grant_id_o, err_cnt_o}), 96'(0));
        chk({name, "_b"}, {fpu_opa_o, fpu_opb_o, fpu_op_o, 24'h0}, 96'(0));
    endtask

    initial begin
        vec_t        v;
        int          r, dly, eg;
        logic [1:0]  er;

        srst = 1'b1;
        req0_valid_i = 0; req1_valid_i = 0; rsp0_ready_i = 0; rsp1_ready_i = 0;
        req0_opa_i = 0; req0_opb_i = 0; req0_op_i = 0;
        req1_opa_i = 0; req1_opb_i = 0; req1_op_i = 0;
        fpu_result_i = 0; fpu_res_ready_i = 0; fpu_flag_i = 0;

        // Contention after reset: grants alternate starting with requester 0.
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(1, 1, 32'h3F80_0000 + i, 32'h4000_0000 + i, 8'(i), 2 + i,
                             32'h1000_0000 + i, 5'(i), 0, i % 2, RESP_OKAY));
        tbl.push_back(mk(1, 0, 32'h3F80_0000, 32'h4000_0000, 8'h01, 3, 32'h4040_0000, 5'h0, 0, 0, RESP_OKAY));
        tbl.push_back(mk(0, 1, 32'h1111_1111, 32'h2222_2222, 8'h02, 0, 32'h0BAD_0BAD, 5'h7, 1, 1, RESP_SLVERR));
        tbl.push_back(mk(1, 0, 32'h3333_3333, 32'h4444_4444, 8'h03, 5, 32'h0000_1234, 5'h3, 0, 0, RESP_OKAY));
        tbl.push_back(mk(0, 1, 32'h5555_5555, 32'h6666_6666, 8'h04, 1, 32'hCAFE_F00D, 5'h1, 2, 1, RESP_OKAY));
        tbl.push_back(mk(1, 1, 32'h7777_7777, 32'h8888_8888, 8'h05, 2, 32'h4120_0000, 5'h8, 10, 0, RESP_OKAY));
        tbl.push_back(mk(0, 1, 32'h9999_9999, 32'hAAAA_AAAA, 8'h06, 4, 32'h4130_0000, 5'h2, 0, 1, RESP_OKAY));
        tbl.push_back(mk(1, 0, 32'hBBBB_BBBB, 32'hCCCC_CCCC, 8'h07, 64, 32'h40A0_0000, 5'h10, 0, 0, RESP_OKAY));
        tbl.push_back(mk(0, 1, 32'hDDDD_DDDD, 32'hEEEE_EEEE, 8'h08, 65, 32'h1234_5678, 5'h4, 1, 1, RESP_SLVERR));

        repeat (3) @(negedge aclk);
        #1;
        chk_all_zero("reset");
        @(negedge aclk);
        srst = 1'b0;

        foreach (tbl[i]) run_op(tbl[i]);

        // Stray result pulse while idle produces nothing.
        @(negedge aclk);
        req0_valid_i = 0; req1_valid_i = 0; rsp0_ready_i = 0; rsp1_ready_i = 0;
        fpu_res_ready_i = 1'b1; fpu_result_i = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk);
            fpu_res_ready_i = 1'b0;
            #1;
            chk("stray_rsp", 96'({rsp1_valid_o, rsp0_valid_o, busy_o, fpu_start_o}), 96'(0));
        end
        chk("stray_err", 96'(err_cnt_o), 96'(m_err));

        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(1, 3);
            if ($urandom_range(0, 9) == 0) dly = 0;
            else if ($urandom_range(0, 5) == 0) dly = $urandom_range(60, 70);
            else dly = $urandom_range(1, 6);
            eg = m_grant(r[0], r[1]);
            er = (dly >= 1 && dly <= 64) ? RESP_OKAY : RESP_SLVERR;
            v = mk(r[0], r[1], $urandom, $urandom, 8'($urandom), dly, $urandom,
                   5'($urandom), $urandom_range(0, 3), eg, er);
            run_op(v);
        end

        for (int i = 0; i < 300; i++) begin
            eg = m_grant(1, 0);
            run_op(mk(1, 0, $urandom, $urandom, 8'h09, 0, 32'h0, 5'h0, 0, eg, RESP_SLVERR));
        end
        @(negedge aclk);
        #1;
        chk("err_saturated", 96'(err_cnt_o), 96'(255));

        // Reset while waiting on the FPU.
        req0_valid_i = 1'b1; req0_opa_i = 32'h0F0F_0F0F; req0_opb_i = 32'hF0F0_F0F0; req0_op_i = 8'h11;
        @(negedge aclk);
        req0_valid_i = 1'b0;
        repeat (3) @(negedge aclk);
        #1;
        chk("pre_reset_busy", 96'(busy_o), 96'(1));
        srst = 1'b1;
        @(negedge aclk);
        srst = 1'b0;
        fpu_res_ready_i = 1'b1; fpu_result_i = 32'h7777_0000; fpu_flag_i = 5'h1F;
        #1;
        chk_all_zero("mid_reset");
        @(negedge aclk);
        fpu_res_ready_i = 1'b0;
        #1;
        chk("late_ignored", 96'({rsp1_valid_o, rsp0_valid_o, busy_o}), 96'(0));
        m_ptr = 0; m_err = 0;
        run_op(mk(0, 1, 32'h3F80_0000, 32'h3F80_0000, 8'h01, 4, 32'h4000_0000, 5'h0, 0, 1, RESP_OKAY));
        @(negedge aclk);
        #1;
        chk("final_idle", 96'({busy_o, err_cnt_o}), 96'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
